// File: rtl/dm_unit.sv
// Data memory for the MEM stage: byte/half/word stores into a word RAM with a
// registered aligned-word read. Define DM_DISPLAY_EN to trace committed stores.
module dm_unit #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  size,
  input  logic        load,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   clr_idx;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic [DEPTH_LOG2-1:0]   idx_p0;
  logic                    in_range_p0;
  logic                    size_ok_p0;
  logic                    misalign_p0;
  logic                    illegal_p0;
  logic                    st_we_p0;
  logic [3:0]              be_p0;
  logic [DATA_W-1:0]       wd_p0;

  function automatic logic [3:0] lane_mask(input logic [2:0] sz, input logic [1:0] ofs);
    case (sz)
      3'd1:    return 4'b0001 << ofs;
      3'd2:    return ofs[1] ? 4'b1100 : 4'b0011;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the right-aligned store data onto every lane it could land in.
  function automatic logic [DATA_W-1:0] lane_data(input logic [2:0] sz, input logic [DATA_W-1:0] d);
    case (sz)
      3'd1:    return {4{d[7:0]}};
      3'd2:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Stage p0: combinational decode of the incoming access
  always_comb begin
    idx_p0      = addr[DEPTH_LOG2+1:2];
    in_range_p0 = (addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2]);
    size_ok_p0  = (size == 3'd0) || (size == 3'd1) || (size == 3'd2) || (size == 3'd4);
    misalign_p0 = ((size == 3'd2) && addr[0]) || ((size == 3'd4) && (addr[1:0] != 2'b00));
    illegal_p0  = !size_ok_p0 || misalign_p0 || (!in_range_p0 && ((size != 3'd0) || load));
    st_we_p0    = reset_n && (state == READY) && en && (size != 3'd0) && !illegal_p0;
    be_p0       = lane_mask(size, addr[1:0]);
    wd_p0       = lane_data(size, wdata);
  end

  // Stage p1: control, clear sequencer and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
      busy    <= 1'b1;
      rdata   <= '0;
      fault   <= 1'b0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == '1) begin
        state <= READY;
        busy  <= 1'b0;
      end
    end else if (en) begin
      fault <= illegal_p0;
      if (load)
        rdata <= in_range_p0 ? mem[idx_p0] : '0;
    end
  end

  // RAM array carries no reset; the clear sequencer owns initialisation.
  always_ff @(posedge clk) begin
    if (reset_n && (state == CLEAR)) begin
      mem[clr_idx] <= '0;
    end else if (st_we_p0) begin
      for (int i = 0; i < 4; i++)
        if (be_p0[i])
          mem[idx_p0][8*i +: 8] <= wd_p0[8*i +: 8];
    end
  end

`ifdef DM_DISPLAY_EN
  logic [DATA_W-1:0] mask_p0;
  logic [DATA_W-1:0] merged_p0;

  always_comb begin
    mask_p0   = {{8{be_p0[3]}}, {8{be_p0[2]}}, {8{be_p0[1]}}, {8{be_p0[0]}}};
    merged_p0 = (mem[idx_p0] & ~mask_p0) | (wd_p0 & mask_p0);
  end

  always_ff @(posedge clk) begin
    if (st_we_p0)
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged_p0);
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
`endif

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data-memory block of the MEM stage; sits directly downstream of the MEM-stage controller and consumes its 3-bit store size code.
- Performs byte, half and word stores into a word-organised RAM.
- Returns the full aligned word for loads, registered into the MEM/WB boundary.
- Signed/unsigned load extension stays in WB.
- After reset, a clear sequencer zeroes the RAM one word per cycle before the block accepts traffic.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words = 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- en  input  1  stage enable; 0 = pipeline stall (hold everything).
- pc  input  32  PC of the instruction in MEM; used for trace only.
- addr  input  32  byte address from ALU.
- wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
- size  input  3  store code: 0 = none, 1 = byte, 2 = half, 4 = word; 3/5/6/7 are illegal.
- load  input  1  load request for this cycle.
- rdata  output  32  registered aligned word read.
- fault  output  1  registered: misaligned, out-of-range or illegal size.
- busy  output  1  high while the clear sequencer runs.

Behaviour:
- Reset (reset_n = 0 at a posedge):
  - state goes to CLEAR, clear index goes to 0, busy = 1, rdata = 0, fault = 0.
  - Asserting reset mid-clear restarts the clear at index 0.
- State CLEAR:
  - Each cycle writes mem[index] = 0 and increments index; en, size and load are ignored.
  - When index = 2^DEPTH_LOG2 - 1 is written, the next state is READY and busy drops on that same edge.
  - Total clear time is 2^DEPTH_LOG2 cycles after reset release.
- State READY: no exit except reset.
- Word index = addr[DEPTH_LOG2+1:2].
- In-range check: addr[31:DEPTH_LOG2+2] == BASE_ADDR[31:DEPTH_LOG2+2].
- Store in READY, committed on the posedge only when en = 1 and the access is legal:
  - byte: lane addr[1:0] takes wdata[7:0].
  - half: addr[0] must be 0; lanes {addr[1],1'b0} and +1 take wdata[15:0], little-endian.
  - word: addr[1:0] must be 00; the full word is written.
  - Unaddressed lanes keep their old contents.
- Illegal access: misaligned half/word, out-of-range address with size != 0 or load = 1, or an illegal size code.
  - No write occurs; fault = 1 from the next edge.
- Fault updates on each posedge with en = 1; it is 0 for legal or idle cycles.
- Load (load = 1, en = 1, in range):
  - rdata <= mem[index] on the posedge (1-cycle latency).
  - Word alignment of addr is not checked here; WB selects the lane.
  - An out-of-range load sets rdata <= 0.
- Load and store to the same word in the same cycle: read-before-write; rdata returns the old word.
- Load = 0 with en = 1: rdata holds its previous value.
- en = 0 in READY: no write; rdata, fault and state are held.
- load and size != 0 together is legal (treated independently).

Optional Feature:
- Macro DM_DISPLAY_EN.
- When defined: every committed store prints "@%h: *%h <= %h" with pc, the word-aligned byte address, and the full merged 32-bit word after the write. One line per store, emitted at the commit edge; no output for faults or CLEAR-phase writes.
- When undefined: no display code is compiled; behaviour is otherwise identical.

Test Plan:
- Reset release, DEPTH_LOG2 = 4 -> busy = 1 for exactly 16 cycles; then a load at addr 0x3C gives rdata = 0.
- sw 0x11223344 @0x10; sb 0xAA @0x11; load @0x10 -> rdata = 0x1122AA44.
- sh 0xBEEF @0x12 over word 0x11223344 -> stored word 0xBEEF3344; sh @0x13 -> fault = 1 next cycle, word unchanged.
- Same-cycle load + sw 0xDEADBEEF @0x20 (old 0) -> rdata = 0; next-cycle load -> 0xDEADBEEF.
- en = 0 with sw @0x04 and load -> no write, rdata/fault held; size = 3 with en = 1 -> fault = 1, no write.
- Reset asserted mid-clear at index 7 -> clear restarts; busy stays high for a full 2^DEPTH_LOG2 cycles after release.
